// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side signals of the unified memory port arbiter.
// slave is the arbiter's view; master is the cpu/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 32
);
  // instruction fetch
  logic                       if_req;
  logic [INST_ADDR_WIDTH-1:0] if_addr;
  logic [INST_WIDTH-1:0]      if_inst;
  logic                       inst_mem_hazard;

  // data stage
  logic                       dm_rd_req;
  logic [DATA_ADDR_WIDTH-1:0] dm_raddr;
  logic [DATA_WIDTH-1:0]      dm_rdata;
  logic                       dm_wr_req;
  logic [DATA_ADDR_WIDTH-1:0] dm_waddr;
  logic [DATA_WIDTH-1:0]      dm_wdata;
  logic                       data_mem_hazard;

  // single-ported memory
  logic                       mem_req;
  logic                       mem_we;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ack;
  logic [DATA_WIDTH-1:0]      mem_rdata;
  logic                       mem_timeout;

  modport slave (
    input  if_req, if_addr, dm_rd_req, dm_raddr, dm_wr_req, dm_waddr, dm_wdata,
           mem_ack, mem_rdata,
    output if_inst, inst_mem_hazard, dm_rdata, data_mem_hazard,
           mem_req, mem_we, mem_addr, mem_wdata, mem_timeout
  );

  modport master (
    output if_req, if_addr, dm_rd_req, dm_raddr, dm_wr_req, dm_waddr, dm_wdata,
           mem_ack, mem_rdata,
    input  if_inst, inst_mem_hazard, dm_rdata, data_mem_hazard,
           mem_req, mem_we, mem_addr, mem_wdata, mem_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and the data stage,
// stalling each requester through its hazard output until its access completes.
module mem_port_arbiter #(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned IW    = INST_WIDTH;
  localparam int unsigned IAW   = INST_ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned DAW   = DATA_ADDR_WIDTH;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DWR  = 2'd2,
    DRD  = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic             mem_req_q,   mem_req_d;
  logic             mem_we_q,    mem_we_d;
  logic [DAW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             wr_done_q,   wr_done_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic             timeout_q,   timeout_d;
  logic [IW-1:0]    inst_q,      inst_d;
  logic [DW-1:0]    rdata_q,     rdata_d;

  logic             ack_inst;
  logic             ack_dwr;
  logic             ack_drd;
  logic             wr_pend;
  logic             inst_hazard;
  logic             data_hazard;
  logic [IAW-1:0]   fetch_addr;

  assign fetch_addr = bus.if_addr;

  // completion strobes only count in the state that owns the port
  assign ack_inst = (state_q == INST) & bus.mem_ack;
  assign ack_dwr  = (state_q == DWR)  & bus.mem_ack;
  assign ack_drd  = (state_q == DRD)  & bus.mem_ack;

  // a write stays requested while the cpu stalls on a following read; wr_done masks it
  assign wr_pend  = bus.dm_wr_req & ~wr_done_q;

  assign inst_hazard = bus.if_req & ~ack_inst;
  assign data_hazard = (wr_pend & ~ack_dwr) | (bus.dm_rd_req & ~ack_drd);

  assign bus.inst_mem_hazard = inst_hazard;
  assign bus.data_mem_hazard = data_hazard;
  assign bus.if_inst         = ack_inst ? IW'(bus.mem_rdata) : inst_q;
  assign bus.dm_rdata        = ack_drd  ? bus.mem_rdata      : rdata_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_timeout     = timeout_q;

  // state register and registered memory-side outputs
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_done_q   <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      inst_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_done_q   <= wr_done_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      inst_q      <= inst_d;
      rdata_q     <= rdata_d;
    end
  end

  // next-state selection, port loading, wait counter and sticky timeout
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_done_d   = wr_done_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    inst_d      = inst_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (wr_pend)            state_d = DWR;
        else if (bus.dm_rd_req) state_d = DRD;
        else if (bus.if_req)    state_d = INST;
      end
      INST: begin
        if (bus.mem_ack) begin
          inst_d = IW'(bus.mem_rdata);
          if (wr_pend)            state_d = DWR;
          else if (bus.dm_rd_req) state_d = DRD;
          else                    state_d = IDLE;
        end
      end
      DWR: begin
        if (bus.mem_ack) begin
          wr_done_d = 1'b1;
          if (bus.dm_rd_req)   state_d = DRD;
          else if (bus.if_req) state_d = INST;
          else                 state_d = IDLE;
        end
      end
      DRD: begin
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          if (bus.if_req) state_d = INST;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy states only change on ack, so "no change" while busy means still waiting
    if (state_d != state_q) begin
      wait_cnt_d = '0;
      mem_req_d  = (state_d != IDLE);
      mem_we_d   = (state_d == DWR);
      unique case (state_d)
        INST: mem_addr_d = DAW'(fetch_addr);
        DWR: begin
          mem_addr_d  = bus.dm_waddr;
          mem_wdata_d = bus.dm_wdata;
        end
        DRD:     mem_addr_d = bus.dm_raddr;
        default: ;
      endcase
    end else if ((state_q != IDLE) && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    if (TO_EN && (state_d == state_q) && (state_q != IDLE) && (wait_cnt_d == CNT_MAX))
      timeout_d = 1'b1;

    // retiring the cpu's data op re-arms the write for the next instruction
    if (!data_hazard && (bus.dm_wr_req || bus.dm_rd_req))
      wr_done_d = 1'b0;
  end

  // a pending memory request keeps its address and direction until acked
  a_req_held: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    (bus.mem_req && !bus.mem_ack) |=> (bus.mem_req && $stable(bus.mem_addr) && $stable(bus.mem_we)));

  a_req_state: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    bus.mem_req == (state_q != IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory model with programmable ack delay,
// cpu request tasks pushing expectations, and a monitor scoreboard popping them.
module tb_mem_port_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(
    .INST_WIDTH(W), .INST_ADDR_WIDTH(W), .DATA_WIDTH(W), .DATA_ADDR_WIDTH(W)
  ) bus ();

  mem_port_arbiter #(
    .INST_WIDTH(W), .INST_ADDR_WIDTH(W), .DATA_WIDTH(W), .DATA_ADDR_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .cpu_clk  (clk),
    .cpu_rst_n(rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_inst[$];
  logic [31:0] exp_rd[$];

  int n_cmp     = 0;
  int n_bad     = 0;
  int n_writes  = 0;
  int ack_delay = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], 16'hC0DE};
  endfunction

  // memory model: acks after ack_delay waiting cycles, one-cycle ack strobe
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end
      if (!bus.mem_req) cnt = 0;
      else if (cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_val(bus.mem_addr);
      end else cnt++;
    end
  end

  // monitor: new memory transactions and retired cpu reads/fetches
  initial begin
    logic prev_req, prev_ack;
    txn_t e;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !(prev_req && !prev_ack)) begin
        if (bus.mem_we) n_writes++;
        if (exp_txn.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL txn_unexpected: got we=%0b addr=0x%08h, expected no transaction",
                   bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_txn.pop_front();
          check("txn_we", 32'(bus.mem_we), 32'(e.we));
          check("txn_addr", bus.mem_addr, e.addr);
          if (e.we) check("txn_wdata", bus.mem_wdata, e.wdata);
        end
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      if (bus.if_req && !bus.inst_mem_hazard) begin
        if (exp_inst.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL inst_unexpected: got if_inst=0x%08h, expected no fetch", bus.if_inst);
        end else check("if_inst", bus.if_inst, exp_inst.pop_front());
      end
      if (bus.dm_rd_req && !bus.data_mem_hazard) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rdata_unexpected: got dm_rdata=0x%08h, expected no read", bus.dm_rdata);
        end else check("dm_rdata", bus.dm_rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output int hz);
    bit done;
    done = 1'b0;
    hz = 0;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.inst_mem_hazard) hz++;
      else done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_stuck: addr 0x%08h hazard still high after 200 cycles, expected completion", a);
    end
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  task automatic data_op(input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                         input bit do_rd, input logic [31:0] ra, output int hz);
    bit done;
    done = 1'b0;
    hz = 0;
    bus.dm_waddr  = wa;
    bus.dm_wdata  = wd;
    bus.dm_raddr  = ra;
    bus.dm_wr_req = do_wr;
    bus.dm_rd_req = do_rd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.data_mem_hazard) hz++;
      else done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL data_stuck: hazard still high after 200 cycles, expected completion");
    end
    @(posedge clk);
    #1;
    bus.dm_wr_req = 1'b0;
    bus.dm_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hz_i, hz_d, w0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_rd_req = 1'b0; bus.dm_raddr = '0;
    bus.dm_wr_req = 1'b0; bus.dm_waddr = '0; bus.dm_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req",   32'(bus.mem_req), 0);
    check("rst_mem_we",    32'(bus.mem_we), 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_timeout",   32'(bus.mem_timeout), 0);
    check("rst_if_inst",   bus.if_inst, 0);
    check("rst_dm_rdata",  bus.dm_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fetch only, ack one cycle after request
    ack_delay = 1;
    exp_txn.push_back(mk(1'b0, 32'h10, 32'h0));
    exp_inst.push_back(32'h0050_0093);
    fetch(32'h10, hz_i);
    check("t1_inst_hazard_cycles", 32'(hz_i), 2);

    // fetch and read together: read goes first, fetch follows with no idle gap
    exp_txn.push_back(mk(1'b0, 32'h40, 32'h0));
    exp_txn.push_back(mk(1'b0, 32'h14, 32'h0));
    exp_rd.push_back(32'h0040_C0DE);
    exp_inst.push_back(32'h0014_C0DE);
    fork
      fetch(32'h14, hz_i);
      data_op(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, hz_d);
    join
    check("t2_data_hazard_cycles", 32'(hz_d), 2);
    check("t2_inst_hazard_cycles", 32'(hz_i), 4);

    // write plus read: one write then the read, hazard held until the read acks
    w0 = n_writes;
    exp_txn.push_back(mk(1'b1, 32'h100, 32'hDEAD_BEEF));
    exp_txn.push_back(mk(1'b0, 32'h104, 32'h0));
    exp_rd.push_back(32'h0104_C0DE);
    data_op(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h104, hz_d);
    check("t3_data_hazard_cycles", 32'(hz_d), 4);
    check("t3_write_count", 32'(n_writes - w0), 1);

    // lone write after that: the write must be re-armed
    exp_txn.push_back(mk(1'b1, 32'h108, 32'hCAFE_F00D));
    data_op(1'b1, 32'h108, 32'hCAFE_F00D, 1'b0, 32'h0, hz_d);
    check("t3b_data_hazard_cycles", 32'(hz_d), 2);
    check("t3b_timeout_clear", 32'(bus.mem_timeout), 0);

    // ack delayed 5 cycles: request held, read arriving later waits its turn
    ack_delay = 5;
    exp_txn.push_back(mk(1'b0, 32'h20, 32'h0));
    exp_txn.push_back(mk(1'b0, 32'h30, 32'h0));
    exp_inst.push_back(32'h0020_C0DE);
    exp_rd.push_back(32'h0030_C0DE);
    fork
      fetch(32'h20, hz_i);
      begin
        @(posedge clk);
        #1;
        data_op(1'b0, 32'h0, 32'h0, 1'b1, 32'h30, hz_d);
      end
      begin
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
          @(negedge clk);
          check("t4_req_held", 32'(bus.mem_req), 1);
          check("t4_addr_held", bus.mem_addr, 32'h20);
        end
      end
    join
    check("t4_inst_hazard_cycles", 32'(hz_i), 6);
    check("t4_data_hazard_cycles", 32'(hz_d), 11);
    check("t4_timeout_set", 32'(bus.mem_timeout), 1);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_timeout_reset", 32'(bus.mem_timeout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // no ack for 10 cycles: timeout after 4 waiting cycles, sticky past the late ack
    ack_delay = 10;
    exp_txn.push_back(mk(1'b0, 32'h50, 32'h0));
    exp_inst.push_back(32'h0050_C0DE);
    fork
      fetch(32'h50, hz_i);
      begin
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k == 4) check("t5_timeout_before", 32'(bus.mem_timeout), 0);
          if (k == 5) check("t5_timeout_after", 32'(bus.mem_timeout), 1);
        end
      end
    join
    check("t5_inst_hazard_cycles", 32'(hz_i), 11);
    check("t5_timeout_sticky", 32'(bus.mem_timeout), 1);

    // async reset in the middle of a write
    exp_txn.push_back(mk(1'b1, 32'h200, 32'h1234_5678));
    bus.dm_waddr  = 32'h200;
    bus.dm_wdata  = 32'h1234_5678;
    bus.dm_wr_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_in_dwr_req", 32'(bus.mem_req), 1);
    check("t6_in_dwr_we",  32'(bus.mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req",   32'(bus.mem_req), 0);
    check("t6_rst_mem_we",    32'(bus.mem_we), 0);
    check("t6_rst_mem_addr",  bus.mem_addr, 0);
    check("t6_rst_mem_wdata", bus.mem_wdata, 0);
    check("t6_rst_timeout",   32'(bus.mem_timeout), 0);
    check("t6_rst_if_inst",   bus.if_inst, 0);
    check("t6_rst_dm_rdata",  bus.dm_rdata, 0);
    bus.dm_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_after_reset", 32'(bus.mem_req), 0);
    end

    check("queues_drained", 32'(exp_txn.size() + exp_inst.size() + exp_rd.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
